// File: rtl/jpeg_rle_block_decoder.sv
// rtl/jpeg_rle_block_decoder.sv - JPEG run-length symbol to 8x8 coefficient block decoder
module jpeg_rle_block_decoder #(
    parameter int COEF_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic                  sym_is_dc,
    input  logic [1:0]            sym_comp,
    input  logic [3:0]            sym_run,
    input  logic [3:0]            sym_size,
    input  logic [10:0]           sym_bits,
    input  logic                  pred_clear,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [COEF_WIDTH-1:0] coef_out,
    output logic [5:0]            coef_index,
    output logic                  blk_last,
    output logic                  error
);

    typedef enum logic [1:0] {
        WAIT_DC = 2'd0,
        AC_FILL = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Zigzag position of each raster index (row*8+col)
    localparam logic [5:0] ZZ_OF_RASTER [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    state_t                  state;
    state_t                  state_next;
    logic [6:0]              pos;
    logic [6:0]              pos_next;
    logic [5:0]              idx;
    logic [63:0]             written;
    logic [COEF_WIDTH-1:0]   coef_mem [64];
    logic [COEF_WIDTH-1:0]   pred [3];
    logic                    err_q;

    logic                    accept;
    logic                    is_eob;
    logic                    is_zrl;
    logic [6:0]              target;
    logic [6:0]              zrl_pos;
    logic [1:0]              comp_sel;
    logic [COEF_WIDTH-1:0]   dc_pred;
    logic [COEF_WIDTH-1:0]   dc_value;
    logic [11:0]             lim;
    logic [11:0]             mag;
    logic [11:0]             amp12;
    logic [COEF_WIDTH-1:0]   amp;
    logic                    amp_err;
    logic                    wr_en;
    logic [5:0]              wr_addr;
    logic [COEF_WIDTH-1:0]   wr_data;
    logic                    dc_take;
    logic                    err_set;
    logic                    idx_adv;
    logic [5:0]              rd_addr;

    assign accept   = sym_valid && sym_ready;
    assign is_eob   = (sym_run == 4'd0) && (sym_size == 4'd0);
    assign is_zrl   = (sym_run == 4'd15) && (sym_size == 4'd0);
    assign target   = pos + {3'b000, sym_run};
    assign zrl_pos  = pos + 7'd16;
    assign comp_sel = (sym_comp == 2'd3) ? 2'd2 : sym_comp;
    assign dc_pred  = pred_clear ? '0 : pred[comp_sel];
    assign dc_value = dc_pred + amp;

    // JPEG amplitude: leading 1 means positive, leading 0 means value minus (2^size - 1)
    always_comb begin
        lim     = '0;
        mag     = '0;
        amp12   = '0;
        amp_err = 1'b0;
        if (sym_size > 4'd11) begin
            amp_err = 1'b1;
        end else if (sym_size != 4'd0) begin
            lim = (12'd1 << sym_size) - 12'd1;
            mag = {1'b0, sym_bits} & lim;
            if ((mag & (12'd1 << (sym_size - 4'd1))) != 12'd0)
                amp12 = mag;
            else
                amp12 = mag - lim;
        end
        amp = COEF_WIDTH'($signed(amp12));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= WAIT_DC;
        else
            state <= state_next;
    end

    // Next-state, symbol handling and handshake outputs
    always_comb begin
        state_next = state;
        pos_next   = pos;
        wr_en      = 1'b0;
        wr_addr    = target[5:0];
        wr_data    = amp;
        dc_take    = 1'b0;
        err_set    = 1'b0;
        sym_ready  = 1'b0;
        blk_valid  = 1'b0;
        idx_adv    = 1'b0;
        case (state)
            WAIT_DC: begin
                sym_ready = !reset;
                if (accept) begin
                    if (sym_is_dc) begin
                        dc_take    = 1'b1;
                        wr_en      = 1'b1;
                        wr_addr    = 6'd0;
                        wr_data    = dc_value;
                        pos_next   = 7'd1;
                        err_set    = amp_err;
                        state_next = AC_FILL;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            AC_FILL: begin
                sym_ready = !reset;
                if (accept) begin
                    if (sym_is_dc) begin
                        err_set = 1'b1;
                    end else if (is_eob) begin
                        state_next = DRAIN;
                    end else if (is_zrl) begin
                        if (zrl_pos > 7'd64) begin
                            err_set    = 1'b1;
                            state_next = DRAIN;
                        end else begin
                            pos_next = zrl_pos;
                            if (zrl_pos == 7'd64)
                                state_next = DRAIN;
                        end
                    end else if (target > 7'd63) begin
                        err_set    = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        wr_en    = 1'b1;
                        err_set  = amp_err;
                        pos_next = target + 7'd1;
                        if (target == 7'd63)
                            state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                blk_valid = !reset;
                if (blk_valid && blk_ready) begin
                    idx_adv = 1'b1;
                    if (idx == 6'd63)
                        state_next = WAIT_DC;
                end
            end
            default: state_next = WAIT_DC;
        endcase
    end

    // Position, drain index, written mask, DC predictors and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            pos     <= '0;
            idx     <= '0;
            written <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 3; i++)
                pred[i] <= '0;
        end else begin
            pos <= pos_next;
            if (idx_adv)
                idx <= idx + 6'd1;
            if (state != WAIT_DC && state_next == WAIT_DC)
                written <= '0;
            else if (wr_en)
                written[wr_addr] <= 1'b1;
            if (err_set)
                err_q <= 1'b1;
            if (pred_clear) begin
                for (int i = 0; i < 3; i++)
                    pred[i] <= '0;
            end
            if (dc_take)
                pred[comp_sel] <= dc_value;
        end
    end

    // Coefficient storage; the written mask makes unwritten entries read as zero
    always_ff @(posedge clock) begin
        if (wr_en)
            coef_mem[wr_addr] <= wr_data;
    end

    assign rd_addr    = ZZ_OF_RASTER[idx];
    assign coef_out   = (blk_valid && written[rd_addr]) ? coef_mem[rd_addr] : '0;
    assign coef_index = idx;
    assign blk_last   = blk_valid && (idx == 6'd63);
    assign error      = err_q;

endmodule

// File: tb/tb_jpeg_rle_block_decoder.sv
// tb/tb_jpeg_rle_block_decoder.sv - scoreboard bench for jpeg_rle_block_decoder
module tb_jpeg_rle_block_decoder;

    typedef struct {
        logic [11:0] coef;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_is_dc;
    logic [1:0]  sym_comp;
    logic [3:0]  sym_run;
    logic [3:0]  sym_size;
    logic [10:0] sym_bits;
    logic        pred_clear;
    logic        blk_valid;
    logic        blk_ready;
    logic [11:0] coef_out;
    logic [5:0]  coef_index;
    logic        blk_last;
    logic        error;

    int vectors = 0;
    int miscompares = 0;

    exp_t               sb[$];
    logic signed [11:0] mblk [64];
    logic signed [11:0] mpred [3];
    int                 mpos;

    // Zigzag position -> raster index
    int nat [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    jpeg_rle_block_decoder #(.COEF_WIDTH(12)) dut (
        .clock      (clock),
        .reset      (reset),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_is_dc  (sym_is_dc),
        .sym_comp   (sym_comp),
        .sym_run    (sym_run),
        .sym_size   (sym_size),
        .sym_bits   (sym_bits),
        .pred_clear (pred_clear),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .coef_out   (coef_out),
        .coef_index (coef_index),
        .blk_last   (blk_last),
        .error      (error)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic signed [11:0] amp_of(input logic [3:0] s, input logic [10:0] b);
        int lim;
        int m;
        int t;
        if (s == 0 || s > 11) return 12'sd0;
        lim = (1 << s) - 1;
        m = int'(b) & lim;
        t = ((m >> (s - 1)) & 1) ? m : m - lim;
        return t[11:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mpred[i] = 12'sd0;
        sb.delete();
    endtask

    task automatic new_block();
        for (int i = 0; i < 64; i++) mblk[i] = 12'sd0;
        mpos = 0;
    endtask

    task automatic send(input bit dc, input logic [1:0] comp, input logic [3:0] run,
                        input logic [3:0] size, input logic [10:0] bits, input bit clr);
        int n = 0;
        sym_valid = 1'b1; sym_is_dc = dc; sym_comp = comp; sym_run = run;
        sym_size = size; sym_bits = bits; pred_clear = clr;
        while (sym_ready !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        if (n == 200) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: sym_ready=%b required 1", sym_ready);
        end else begin
            @(negedge clock);
        end
        sym_valid = 1'b0; pred_clear = 1'b0;
    endtask

    task automatic put_dc(input logic [1:0] comp, input logic [3:0] size,
                          input logic [10:0] bits, input bit clr);
        int ci;
        if (clr) for (int i = 0; i < 3; i++) mpred[i] = 12'sd0;
        ci = (comp == 2'd3) ? 2 : int'(comp);
        mpred[ci] = mpred[ci] + amp_of(size, bits);
        mblk[0] = mpred[ci];
        mpos = 1;
        send(1'b1, comp, 4'd0, size, bits, clr);
    endtask

    task automatic put_ac(input logic [3:0] run, input logic [3:0] size, input logic [10:0] bits);
        int t;
        if (run == 0 && size == 0) begin
        end else if (run == 15 && size == 0) begin
            if (mpos + 16 <= 64) mpos += 16;
        end else begin
            t = mpos + int'(run);
            if (t <= 63) begin mblk[t] = amp_of(size, bits); mpos = t + 1; end
        end
        send(1'b0, 2'd0, run, size, bits, 1'b0);
    endtask

    task automatic push_block();
        logic signed [11:0] ras [64];
        exp_t e;
        for (int z = 0; z < 64; z++) ras[nat[z]] = mblk[z];
        for (int r = 0; r < 64; r++) begin
            e.coef = ras[r]; e.idx = 6'(r); e.last = (r == 63);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name, input int stall_at, input int reset_at);
        exp_t e;
        int n;
        blk_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            n = 0;
            while (blk_valid !== 1'b1 && n < 200) begin @(negedge clock); n++; end
            if (n == 200) begin
                vectors++; miscompares++;
                $display("FAIL %s_valid_timeout: blk_valid=%b required 1 at output %0d", name, blk_valid, i);
                sb.delete();
                return;
            end
            e = sb.pop_front();
            vectors++;
            if ({coef_out, coef_index, blk_last} !== {e.coef, e.idx, e.last}) begin
                miscompares++;
                $display("FAIL %s_out: coef=%0d idx=%0d last=%b required coef=%0d idx=%0d last=%b",
                         name, $signed(coef_out), coef_index, blk_last, $signed(e.coef), e.idx, e.last);
            end
            if (i == stall_at) begin
                blk_ready = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    vectors++;
                    if ({coef_out, coef_index, sym_ready, blk_valid} !== {e.coef, e.idx, 1'b0, 1'b1}) begin
                        miscompares++;
                        $display("FAIL %s_stall: coef=%0d idx=%0d sym_ready=%b blk_valid=%b required coef=%0d idx=%0d 0 1",
                                 name, $signed(coef_out), coef_index, sym_ready, blk_valid, $signed(e.coef), e.idx);
                    end
                end
                blk_ready = 1'b1;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                vectors++;
                if ({blk_valid, error} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL %s_reset: blk_valid=%b error=%b required 0 0", name, blk_valid, error);
                end
                reset = 1'b0;
                model_reset();
                @(negedge clock);
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic check_error(input string name, input logic want);
        vectors++;
        if (error !== want) begin
            miscompares++;
            $display("FAIL %s: error=%b required %b", name, error, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if ({sym_ready, blk_valid, coef_out, coef_index, blk_last, error} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b vld=%b coef=%0d idx=%0d last=%b err=%b required all 0",
                     sym_ready, blk_valid, coef_out, coef_index, blk_last, error);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        vectors++;
        if (sym_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: sym_ready=%b required 1", sym_ready);
        end
    endtask

    task automatic test_dc_eob();
        new_block();
        put_dc(2'd0, 4'd3, 11'b101, 1'b0);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("dc_eob", -1, -1);
        check_error("dc_eob_error", 1'b0);
    endtask

    task automatic test_prediction();
        new_block();
        put_dc(2'd0, 4'd2, 11'b01, 1'b0);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("pred_comp0", -1, -1);
        new_block();
        put_dc(2'd1, 4'd0, 11'd0, 1'b0);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("pred_comp1", -1, -1);
        new_block();
        put_dc(2'd0, 4'd0, 11'd0, 1'b1);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("pred_clear", -1, -1);
    endtask

    task automatic test_ac_placement();
        new_block();
        put_dc(2'd0, 4'd0, 11'd0, 1'b0);
        put_ac(4'd1, 4'd1, 11'b0);
        put_ac(4'd15, 4'd0, 11'd0);
        put_ac(4'd0, 4'd2, 11'b11);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("ac_place", -1, -1);
    endtask

    task automatic test_full_block();
        new_block();
        put_dc(2'd0, 4'd0, 11'd0, 1'b0);
        for (int i = 0; i < 63; i++) put_ac(4'd0, 4'd1, 11'b1);
        vectors++;
        if ({blk_valid, sym_ready, coef_index} !== {1'b1, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL full_drain_start: blk_valid=%b sym_ready=%b idx=%0d required 1 0 0",
                     blk_valid, sym_ready, coef_index);
        end
        push_block();
        drain("full", -1, -1);
        check_error("full_error", 1'b0);
    endtask

    task automatic test_overrun();
        new_block();
        put_dc(2'd0, 4'd0, 11'd0, 1'b0);
        for (int i = 0; i < 4; i++) put_ac(4'd15, 4'd1, 11'b1);
        vectors++;
        if ({error, blk_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL overrun_state: error=%b blk_valid=%b required 1 1", error, blk_valid);
        end
        push_block();
        drain("overrun", -1, -1);
        check_error("overrun_sticky", 1'b1);
    endtask

    task automatic test_backpressure_reset();
        new_block();
        put_dc(2'd0, 4'd4, 11'b1010, 1'b0);
        put_ac(4'd2, 4'd3, 11'b011);
        put_ac(4'd5, 4'd5, 11'b10001);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("bp", 10, 20);
        new_block();
        put_dc(2'd0, 4'd3, 11'b101, 1'b0);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("after_reset", -1, -1);
    endtask

    task automatic test_protocol_errors();
        check_error("proto_clean", 1'b0);
        send(1'b0, 2'd0, 4'd0, 4'd1, 11'b1, 1'b0);
        vectors++;
        if ({error, sym_ready, blk_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL proto_ac_in_wait: error=%b sym_ready=%b blk_valid=%b required 1 1 0",
                     error, sym_ready, blk_valid);
        end
        new_block();
        put_dc(2'd3, 4'd2, 11'b10, 1'b0);
        send(1'b1, 2'd2, 4'd0, 4'd3, 11'b111, 1'b0);
        put_ac(4'd0, 4'd1, 11'b1);
        put_ac(4'd0, 4'd12, 11'd5);
        put_ac(4'd0, 4'd0, 11'd0);
        push_block();
        drain("proto", -1, -1);
        check_error("proto_sticky", 1'b1);
    endtask

    initial begin
        reset = 1'b1; sym_valid = 1'b0; sym_is_dc = 1'b0; sym_comp = 2'd0;
        sym_run = 4'd0; sym_size = 4'd0; sym_bits = 11'd0; pred_clear = 1'b0;
        blk_ready = 1'b1;
        @(negedge clock);
        test_reset();
        test_dc_eob();
        test_prediction();
        test_ac_placement();
        test_full_block();
        test_overrun();
        test_backpressure_reset();
        test_protocol_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
